// File: rtl/sram_pkg.sv
// Shared constants and helpers for the SRAM wordline decoder.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_WIDTH  = 6;
  localparam int unsigned SRAM_NUM_ROWS    = 64;
  localparam int unsigned SRAM_PREDEC_BITS = 3;

  // Number of predecode groups the address is split into, LSB group first.
  function automatic int unsigned num_groups(input int unsigned aw, input int unsigned pb);
    return (aw + pb - 1) / pb;
  endfunction

  // Width of group g; only the last group may be narrower than pb.
  function automatic int unsigned group_width(input int unsigned aw, input int unsigned pb,
                                              input int unsigned g);
    int unsigned rem;
    rem = aw - g * pb;
    return (rem < pb) ? rem : pb;
  endfunction

endpackage

// File: rtl/sram_predecoder.sv
// Combinational binary-to-one-hot predecoder for one address group.
module sram_predecoder #(
  parameter int unsigned W = 3
) (
  input  logic [W-1:0]      in_i,
  output logic [2**W-1:0]   onehot_o
);

  always_comb begin
    onehot_o       = '0;
    onehot_o[in_i] = 1'b1;
  end

endmodule

// File: rtl/sram_row_decoder.sv
// Registered SRAM wordline decoder: grouped predecode, final AND matrix, range check.
module sram_row_decoder
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = SRAM_ADDR_WIDTH,
  parameter int unsigned NUM_ROWS    = SRAM_NUM_ROWS,
  parameter int unsigned PREDEC_BITS = SRAM_PREDEC_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  enable_i,
  output logic [NUM_ROWS-1:0]   row_select_o,
  output logic                  row_active_o,
  output logic                  addr_err_o
);

  localparam int unsigned NumGroups = num_groups(ADDR_WIDTH, PREDEC_BITS);
  localparam int unsigned PredW     = 2 ** PREDEC_BITS;

  // Narrow last group is zero-padded so every group indexes the same way.
  logic [PredW-1:0] pre_lines [NumGroups];

  for (genvar g = 0; g < NumGroups; g++) begin : g_group
    localparam int unsigned Lo = g * PREDEC_BITS;
    localparam int unsigned Gw = group_width(ADDR_WIDTH, PREDEC_BITS, g);

    logic [2**Gw-1:0] onehot;

    sram_predecoder #(
      .W (Gw)
    ) u_predec (
      .in_i     (addr_i[Lo +: Gw]),
      .onehot_o (onehot)
    );

    assign pre_lines[g] = PredW'(onehot);
  end

  logic [NUM_ROWS-1:0] row_select_d, row_select_q;
  logic                row_active_d, row_active_q;
  logic                addr_err_d, addr_err_q;

  // Only rows below NUM_ROWS exist, so an out-of-range address hits nothing.
  always_comb begin
    row_select_d = '0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      row_select_d[r] = enable_i;
      for (int unsigned g = 0; g < NumGroups; g++) begin
        row_select_d[r] = row_select_d[r] &
                          pre_lines[g][PREDEC_BITS'(r >> (g * PREDEC_BITS))];
      end
    end
    row_active_d = |row_select_d;
    addr_err_d   = enable_i & (32'(addr_i) >= NUM_ROWS);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_select_q <= '0;
      row_active_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      row_select_q <= row_select_d;
      row_active_q <= row_active_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign row_select_o = row_select_q;
  assign row_active_o = row_active_q;
  assign addr_err_o   = addr_err_q;

endmodule

// File: tb/tb_sram_row_decoder.sv
// Bench for sram_row_decoder: 64-row and 40-row instances against a behavioural model.
module tb_sram_row_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [5:0]  addr;

  logic [63:0] sel64;
  logic        act64, err64;
  logic [39:0] sel40;
  logic        act40, err40;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_sel64, exp_sel40;
  logic        exp_err64, exp_err40;

  always #5 clk = ~clk;

  sram_row_decoder dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .addr_i       (addr),
    .enable_i     (enable),
    .row_select_o (sel64),
    .row_active_o (act64),
    .addr_err_o   (err64)
  );

  sram_row_decoder #(
    .ADDR_WIDTH  (6),
    .NUM_ROWS    (40),
    .PREDEC_BITS (3)
  ) dut40 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .addr_i       (addr),
    .enable_i     (enable),
    .row_select_o (sel40),
    .row_active_o (act40),
    .addr_err_o   (err40)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  // Model: a row fires iff enabled and the address names an existing row.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_sel64 <= '0;
      exp_sel40 <= '0;
      exp_err64 <= 1'b0;
      exp_err40 <= 1'b0;
    end else if (enable === 1'b1) begin
      exp_sel64 <= (64'd1 << addr);
      exp_sel40 <= (int'(addr) < 40) ? (64'd1 << addr) : 64'd0;
      exp_err64 <= 1'b0;
      exp_err40 <= (int'(addr) >= 40);
    end else begin
      exp_sel64 <= '0;
      exp_sel40 <= '0;
      exp_err64 <= 1'b0;
      exp_err40 <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("model_sel64", sel64, exp_sel64);
    chk("model_act64", 64'(act64), 64'(exp_sel64 != 0));
    chk("model_err64", 64'(err64), 64'(exp_err64));
    chk("model_sel40", 64'(sel40), exp_sel40);
    chk("model_act40", 64'(act40), 64'(exp_sel40 != 0));
    chk("model_err40", 64'(err40), 64'(exp_err40));
    chk("onehot0_64", 64'($onehot0(sel64)), 64'd1);
    chk("onehot0_40", 64'($onehot0(sel40)), 64'd1);
  end

  task automatic drive(input logic en, input logic [5:0] a);
    @(negedge clk);
    enable = en;
    addr   = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    addr   = 6'd5;
    #1;
    chk("reset_nolock_sel", sel64, 64'd0);
    chk("reset_nolock_act", 64'(act64), 64'd0);
    chk("reset_nolock_err", 64'(err64), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_clocked_sel", sel64, 64'd0);
    chk("reset_clocked_act", 64'(act64), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 6'(i));
      chk("sweep_sel", sel64, 64'd1 << i);
      chk("sweep_act", 64'(act64), 64'd1);
      chk("sweep_err", 64'(err64), 64'd0);
    end

    drive(1'b1, 6'd10);
    chk("latency_a10", sel64, 64'h0000_0000_0000_0400);
    drive(1'b1, 6'd42);
    chk("latency_a42", sel64, 64'h0000_0400_0000_0000);

    for (int i = 0; i < 64; i++) begin
      drive(1'b0, (i % 8 == 7) ? 6'bx : 6'(i));
      chk("disabled_sel", sel64, 64'd0);
      chk("disabled_act", 64'(act64), 64'd0);
    end
    drive(1'b1, 6'd63);
    chk("enable_a63", sel64, 64'h8000_0000_0000_0000);
    chk("r40_a63_sel", 64'(sel40), 64'd0);
    chk("r40_a63_err", 64'(err40), 64'd1);

    drive(1'b1, 6'd39);
    chk("r40_a39_sel", 64'(sel40), 64'h0000_0080_0000_0000);
    chk("r40_a39_err", 64'(err40), 64'd0);
    drive(1'b1, 6'd40);
    chk("r40_a40_sel", 64'(sel40), 64'd0);
    chk("r40_a40_act", 64'(act40), 64'd0);
    chk("r40_a40_err", 64'(err40), 64'd1);
    chk("r64_a40_sel", sel64, 64'h0000_0100_0000_0000);
    drive(1'b1, 6'd20);
    chk("r40_err_clears", 64'(err40), 64'd0);

    drive(1'b1, 6'd17);
    chk("mid_before_sel", sel64, 64'h0000_0000_0002_0000);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_async_sel", sel64, 64'd0);
    chk("mid_async_act", 64'(act64), 64'd0);
    chk("mid_async_sel40", 64'(sel40), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_release_sel", sel64, 64'd0);
    @(posedge clk);
    #1;
    chk("mid_after_sel", sel64, 64'h0000_0000_0002_0000);
    chk("mid_after_act", 64'(act64), 64'd1);

    drive(1'b0, 6'd0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_row_decoder.md
Name: sram_row_decoder

Overview:
- Wordline (row) decoder for the SRAM macro: converts a binary row address into a one-hot row_select vector that drives the array wordlines.
- Sits between the SRAM controller (addr, enable) and the bit-cell array.
- Output is registered so wordlines are glitch-free.
- Implemented as two-level predecode plus a final AND stage.

Parameters:
- ADDR_WIDTH, 6, row address width in bits; legal range 1..10.
- NUM_ROWS, 64, number of physical rows; legal range 2..2**ADDR_WIDTH.
- PREDEC_BITS, 3, address bits per predecode group; the last group may be narrower.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- addr  input  ADDR_WIDTH  binary row address.
- enable  input  1  wordline enable; no row is selected when low.
- row_select  output  NUM_ROWS  registered one-hot wordline vector; bit i selects row i.
- row_active  output  1  registered; high when any row_select bit is high.
- addr_err  output  1  registered; high when enable was high with addr >= NUM_ROWS.

Behaviour:
- Reset: rst_n low clears row_select, row_active and addr_err to 0 immediately, without waiting for clk. They stay 0 while rst_n is low.
- Release: outputs first update on the first rising clk edge after rst_n deasserts.
- Latency: exactly 1 cycle. addr/enable sampled at rising edge N appear on the outputs after edge N.
- No internal state besides the output registers. Every cycle is independent, so back-to-back address changes are allowed with no bubbles.
- Next-state rules, for enable=1 and addr < NUM_ROWS:
  - row_select = 1 << addr (exactly one bit set)
  - row_active = 1
  - addr_err = 0
- Next-state rules, for enable=1 and addr >= NUM_ROWS (only possible when NUM_ROWS < 2**ADDR_WIDTH):
  - row_select = all zero; no wordline may fire
  - row_active = 0
  - addr_err = 1 for that cycle only
- Next-state rules, for enable=0:
  - row_select = 0, row_active = 0, addr_err = 0, regardless of addr
  - X on addr while enable=0 must not propagate into row_select
- Invariant: row_select is zero-hot or one-hot at all times. row_active == |row_select at all times.
- Predecode structure:
  - addr is split into ceil(ADDR_WIDTH/PREDEC_BITS) groups, LSB group first.
  - Each group drives a one-hot predecoder of width 2**group_width.
  - row i = AND of the predecode lines selected by the bit-fields of i, gated by enable.
  - Result is masked to NUM_ROWS bits before the register.
- Reset mid-operation: asserting rst_n while a row is selected drops row_select to 0 asynchronously. The next selection occurs only after release plus a clock edge with enable=1.
- No clock gating; registers update every edge.

Decomposition:
- Shared package sram_pkg holds:
  - default constants SRAM_ADDR_WIDTH=6, SRAM_NUM_ROWS=64, SRAM_PREDEC_BITS=3
  - a function computing the predecode group count
- One natural sub-module: sram_predecoder.
  - Parameter W; input [W-1:0] in; output [2**W-1:0] onehot.
  - Purely combinational; instantiated once per address group via generate.
- Top level (sram_row_decoder) holds: generate loops, final AND matrix, range check, output registers.

Test Plan:
- Reset: drive rst_n=0 with enable=1, addr=5 while clocking -> row_select=0, row_active=0, addr_err=0; they remain 0 with no clock edge needed.
- Exhaustive sweep: enable=1, addr=0..63 on consecutive cycles -> each cycle after the edge, row_select == 64'h1<<addr, row_active=1, addr_err=0.
- Latency: addr=10 then addr=42 on consecutive edges -> row_select shows bit 10 after the first edge and bit 42 after the second; never both set.
- Enable gating: enable=0, addr sweeps 0..63 including X -> row_select=0, row_active=0 every cycle; then enable=1, addr=63 -> row_select=64'h8000_0000_0000_0000.
- Out of range: parameters ADDR_WIDTH=6, NUM_ROWS=40; enable=1, addr=39 -> bit 39 set, addr_err=0; addr=40 and addr=63 -> row_select=0, row_active=0, addr_err=1.
- Async reset mid-operation: enable=1, addr=17, row_select=bit 17; assert rst_n=0 between edges -> row_select=0 immediately; release -> bit 17 again after the next edge.
